prim_xor_tree_pipe: RTL and testbench

- Parametrised, pipelined N-input bitwise XOR reduction with valid/ready handshake on both sides.
- Primary use: recombining NumIn masked shares into a cleartext word. Also usable for wide parity/whitening on datapaths where a flat XOR would break timing.
- The XOR tree is split into log2 levels with one register stage per level.
- Sits between a share-producing source and any consumer that may stall.

---
 rtl/prim_xor_tree_pipe.sv | 115 +++++++++++
 tb/tb_prim_xor_tree_pipe.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/prim_xor_tree_pipe.sv
// Pipelined N-input XOR (optionally XNOR) reduction tree, one register stage per tree level,
// with a valid/ready handshake on both sides and a combinational ready chain.
module prim_xor_tree_pipe #(
    parameter int unsigned Width  = 32,
    parameter int unsigned NumIn  = 4,
    parameter bit          Invert = 1'b0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [NumIn*Width-1:0] in_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [Width-1:0]       out_o,
    output logic                   busy_o
);

    localparam int unsigned Latency = (NumIn > 2) ? $clog2(NumIn) : 1;

    // Operand count entering tree level `level` (ceil-halving per level).
    function automatic int unsigned ops_at(input int unsigned level);
        int unsigned n;
        n = NumIn;
        for (int unsigned i = 0; i < level; i++) n = (n + 1) / 2;
        return n;
    endfunction

    logic [Latency-1:0] valid_q, valid_d;
    logic [Latency:0]   adv;
    logic               in_fire;

    // A stage may take new data when it is empty or its successor is moving.
    always_comb begin
        logic a;
        a            = out_ready_i;
        adv          = '0;
        adv[Latency] = out_ready_i;
        for (int unsigned s = Latency; s > 0; s--) begin
            a        = ~valid_q[s-1] | a;
            adv[s-1] = a;
        end
    end

    assign in_ready_o = adv[0] & ~flush_i;
    assign in_fire    = in_valid_i & in_ready_o;

    always_comb begin
        valid_d = valid_q;
        if (flush_i) begin
            valid_d = '0;
        end else begin
            if (adv[0]) valid_d[0] = in_fire;
            for (int unsigned s = 1; s < Latency; s++) begin
                if (adv[s]) valid_d[s] = valid_q[s-1];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) valid_q <= '0;
        else       valid_q <= valid_d;
    end

    for (genvar s = 0; s < Latency; s++) begin : g_stage
        localparam int unsigned NI = ops_at(s);
        localparam int unsigned NO = ops_at(s + 1);

        logic [NI*Width-1:0] src;
        logic [NO*Width-1:0] data_d, data_q;
        logic                load;

        if (s == 0) begin : g_first
            assign src  = in_i;
            assign load = in_fire;
        end else begin : g_next
            assign src  = g_stage[s-1].data_q;
            assign load = adv[s] & valid_q[s-1];
        end

        // Pair j = op[2j] ^ op[2j+1]; an odd trailing operand passes through.
        always_comb begin
            int unsigned b;
            data_d = '0;
            for (int unsigned j = 0; j < NO; j++) begin
                b = (2 * j + 1 < NI) ? 2 * j + 1 : 2 * j;
                data_d[j*Width +: Width] = src[2*j*Width +: Width];
                if (2 * j + 1 < NI) begin
                    data_d[j*Width +: Width] = data_d[j*Width +: Width] ^ src[b*Width +: Width];
                end
            end
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i)     data_q <= '0;
            else if (load) data_q <= data_d;
        end
    end

    assign out_valid_o = valid_q[Latency-1];
    assign out_o       = g_stage[Latency-1].data_q ^ {Width{Invert}};
    assign busy_o      = |valid_q;

`ifndef SYNTHESIS
    a_params : assert property (@(posedge clk_i) (Width >= 1) && (NumIn >= 1) && (NumIn <= 16));

    a_out_stable : assert property (@(posedge clk_i) disable iff (rst_i)
        (out_valid_o && !out_ready_i && !flush_i) |=> (out_valid_o && $stable(out_o)));

    a_no_x : assert property (@(posedge clk_i) disable iff (rst_i)
        !$isunknown({out_valid_o, in_ready_o}));
`endif

endmodule

// File: tb/tb_prim_xor_tree_pipe.sv
// Scoreboard bench for prim_xor_tree_pipe: stimulus pushes expected words, a negedge monitor
// pops and compares on every output transfer of three differently-parameterised instances.
module tb_prim_xor_tree_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Main instance (32x4, XOR) and its XNOR twin share all inputs.
    logic          rst, flush, in_valid, out_ready;
    logic [127:0]  in_w;
    logic          in_ready, out_valid, busy;
    logic [31:0]   out_w;
    logic          in_ready3, out_valid3, busy3;
    logic [31:0]   out_w3;

    // Small odd-count instance (8x3).
    logic          in_valid2, out_ready2;
    logic [23:0]   in_w2;
    logic          in_ready2, out_valid2, busy2;
    logic [7:0]    out_w2;

    prim_xor_tree_pipe #(.Width(32), .NumIn(4), .Invert(1'b0)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_i(in_w), .out_valid_o(out_valid), .out_ready_i(out_ready), .out_o(out_w), .busy_o(busy));

    prim_xor_tree_pipe #(.Width(32), .NumIn(4), .Invert(1'b1)) dut_inv (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready3),
        .in_i(in_w), .out_valid_o(out_valid3), .out_ready_i(out_ready), .out_o(out_w3), .busy_o(busy3));

    prim_xor_tree_pipe #(.Width(8), .NumIn(3), .Invert(1'b0)) dut_odd (
        .clk_i(clk), .rst_i(rst), .flush_i(1'b0), .in_valid_i(in_valid2), .in_ready_o(in_ready2),
        .in_i(in_w2), .out_valid_o(out_valid2), .out_ready_i(out_ready2), .out_o(out_w2), .busy_o(busy2));

    typedef struct {
        logic [31:0] d;
        bit          lat;
        int unsigned t;
    } ent_t;

    ent_t q1[$];
    ent_t q3[$];
    ent_t q2[$];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: a transfer happens at the next rising edge when valid & ready are seen here.
    always @(negedge clk) begin
        ent_t e;
        if (!rst && out_valid && out_ready) begin
            if (q1.size() == 0) chk("xor_unexpected_output", 32'(q1.size()), 32'd1);
            else begin
                e = q1.pop_front();
                chk("xor_out", out_w, e.d);
                if (e.lat) chk("xor_latency", cyc - e.t, 32'd2);
            end
        end
        if (!rst && out_valid3 && out_ready) begin
            if (q3.size() == 0) chk("xnor_unexpected_output", 32'(q3.size()), 32'd1);
            else begin
                e = q3.pop_front();
                chk("xnor_out", out_w3, e.d);
            end
        end
        if (!rst && out_valid2 && out_ready2) begin
            if (q2.size() == 0) chk("odd_unexpected_output", 32'(q2.size()), 32'd1);
            else begin
                e = q2.pop_front();
                chk("odd_out", {24'h0, out_w2}, e.d);
                if (e.lat) chk("odd_latency", cyc - e.t, 32'd2);
            end
        end
    end

    function automatic logic [31:0] ref_xor(input logic [127:0] v);
        return v[31:0] ^ v[63:32] ^ v[95:64] ^ v[127:96];
    endfunction

    task automatic send(input logic [127:0] d, input logic [31:0] e1, input logic [31:0] e3,
                        input bit lat, output int unsigned waited);
        waited   = 0;
        in_w     = d;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                q1.push_back('{d: e1, lat: lat, t: cyc});
                q3.push_back('{d: e3, lat: 1'b0, t: cyc});
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
            waited++;
            if (waited > 50) begin
                chk("send_timeout", 32'(in_ready), 32'd1);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic send2(input logic [23:0] d, input logic [7:0] e);
        int unsigned n;
        n         = 0;
        in_w2     = d;
        in_valid2 = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready2) begin
                q2.push_back('{d: {24'h0, e}, lat: 1'b1, t: cyc});
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
            n++;
            if (n > 50) begin
                chk("send2_timeout", 32'(in_ready2), 32'd1);
                break;
            end
        end
        in_valid2 = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (q1.size() == 0 && q3.size() == 0 && q2.size() == 0) break;
        end
        chk(name, 32'(q1.size() + q3.size() + q2.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] w;
        logic [127:0] bpw [4];
        logic [31:0]  held;
        int unsigned  waited, stalls, acc;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_w = '0;
        in_valid2 = 1'b0; out_ready2 = 1'b1; in_w2 = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out", out_w, 32'h0000_0000);
        chk("rst_out_inv", out_w3, 32'hFFFF_FFFF);
        chk("rst_odd_valid", 32'(out_valid2), 32'd0);
        @(posedge clk); #1;

        // Directed vectors: operand 0 is the least-significant word.
        send({32'h12345678, 32'h00FF00FF, 32'h0F0F0F0F, 32'hFFFF0000},
             32'hE23B5988, 32'h1DC4A677, 1'b1, waited);
        send({32'h0, 32'h0, 32'h0, 32'h0}, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1, waited);
        send({32'hFFFFFFFF, 32'h0, 32'h0, 32'h0}, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, waited);
        send({4{32'hDEADBEEF}}, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, waited);
        send({32'h80000001, 32'h40000002, 32'h20000004, 32'h10000008},
             32'hF000000F, 32'h0FFFFFF0, 1'b0, waited);
        drain("directed_drain");

        send2({8'h0F, 8'h5A, 8'hA5}, 8'hF0);
        send2({8'h04, 8'h02, 8'h01}, 8'h07);
        send2({8'hFF, 8'hFF, 8'h3C}, 8'h3C);
        drain("odd_drain");

        stalls = 0;
        for (int i = 0; i < 100; i++) begin
            w = {32'(i) * 32'h9E3779B9, 32'(i) ^ 32'hA5A5_0000,
                 32'(i) * 32'h7F4A7C15 + 32'd3, ~32'(i)};
            send(w, ref_xor(w), ~ref_xor(w), 1'b0, waited);
            stalls += waited;
        end
        chk("stream_no_stall", stalls, 32'd0);
        drain("stream_drain");

        out_ready = 1'b0;
        bpw[0] = {32'h1, 32'h2, 32'h4, 32'h8};
        bpw[1] = {32'hAAAA5555, 32'h0, 32'h0, 32'h0};
        bpw[2] = {32'hCAFEF00D, 32'h0, 32'h1, 32'h0};
        bpw[3] = {32'h0, 32'h0, 32'h0, 32'h1234};
        acc = 0;
        in_valid = 1'b1;
        for (int a = 0; a < 4; a++) begin
            in_w = bpw[acc];
            @(negedge clk);
            if (in_ready) begin
                q1.push_back('{d: ref_xor(bpw[acc]), lat: 1'b0, t: cyc});
                q3.push_back('{d: ~ref_xor(bpw[acc]), lat: 1'b0, t: cyc});
                acc++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("bp_accepted", acc, 32'd2);
        @(negedge clk);
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        chk("bp_busy", 32'(busy), 32'd1);
        held = out_w;
        chk("bp_head_value", held, 32'h0000_000F);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_out_stable", out_w, held);
            chk("bp_valid_stable", 32'(out_valid), 32'd1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        drain("bp_drain");

        out_ready = 1'b0;
        send({32'h11111111, 32'h0, 32'h0, 32'h0}, 32'h11111111, 32'hEEEEEEEE, 1'b0, waited);
        send({32'h22222222, 32'h0, 32'h0, 32'h0}, 32'h22222222, 32'hDDDDDDDD, 1'b0, waited);
        flush = 1'b1;
        @(negedge clk);
        chk("flush_in_ready_low", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        q1.delete();
        q3.delete();
        @(negedge clk);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        send({32'h0, 32'h0, 32'h00F0, 32'h0F00}, 32'h0000_0FF0, 32'hFFFF_F00F, 1'b1, waited);
        drain("flush_drain");

        send({32'h5, 32'h0, 32'h0, 32'h0}, 32'h5, 32'hFFFF_FFFA, 1'b0, waited);
        send({32'h6, 32'h0, 32'h0, 32'h0}, 32'h6, 32'hFFFF_FFF9, 1'b0, waited);
        rst = 1'b1;
        q1.delete();
        q3.delete();
        @(negedge clk);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("postrst_out_valid", 32'(out_valid), 32'd0);
        chk("postrst_busy", 32'(busy), 32'd0);
        chk("postrst_in_ready", 32'(in_ready), 32'd1);
        repeat (5) @(posedge clk);
        #1;
        send({32'h0, 32'h0, 32'h0, 32'h600D}, 32'h0000_600D, 32'hFFFF_9FF2, 1'b1, waited);
        drain("final_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
